// File: rtl/mux4_arb_pkg.sv
// mux4_arb_pkg: shared types and constants for the round-robin 4:1 mux arbiter
package mux4_arb_pkg;
    localparam int N_REQ = 4;
    typedef logic [1:0] sel_t;
    typedef logic [3:0] reqvec_t;
    typedef enum logic {EMPTY, FULL} occ_t;
endpackage

// File: rtl/mux4_1.sv
// mux4_1: plain 4:1 data mux shared by all requesters
module mux4_1 #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] w,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] data
);
    // Select one of the four words
    always_comb begin
        data = sel[1] ? (sel[0] ? z : y) : (sel[0] ? x : w);
    end
endmodule

// File: rtl/rr_pick4.sv
// rr_pick4: rotating-priority encoder, first eligible bit at or after ptr wins
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  reqvec_t elig,
    input  sel_t    ptr,
    output logic    any,
    output sel_t    winner
);
    logic [7:0] dbl;
    logic [3:0] rot;
    sel_t       off;

    assign dbl = {elig, elig};

    // Rotate so ptr sits at bit 0, find the first set bit, then undo the rotation
    always_comb begin
        rot    = dbl[ptr +: 4];
        off    = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        winner = ptr + off;
        any    = |elig;
    end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin grant of a shared 4:1 mux into a one-entry output register
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int RESET_PTR = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [3:0]       req_en,
    input  logic [WIDTH-1:0] w,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    output logic [3:0]       ack,
    output logic [1:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src
);
    occ_t             occ, occ_next;
    sel_t             ptr, last_sel, winner;
    reqvec_t          elig;
    logic             any, free, grant;
    logic [WIDTH-1:0] mux_data;

    // Requests are masked while reset is asserted so no ack escapes during reset
    assign elig      = req & req_en & {N_REQ{rst_n}};
    assign out_valid = (occ == FULL);
    assign free      = !out_valid || out_ready;
    assign grant     = free && any;

    rr_pick4 u_pick (
        .elig   (elig),
        .ptr    (ptr),
        .any    (any),
        .winner (winner)
    );

    mux4_1 #(.WIDTH(WIDTH)) u_mux (
        .w    (w),
        .x    (x),
        .y    (y),
        .z    (z),
        .sel  (sel),
        .data (mux_data)
    );

    // Grant decode, mux select and occupancy next state
    always_comb begin
        ack      = grant ? reqvec_t'(4'b0001 << winner) : '0;
        sel      = grant ? winner : last_sel;
        occ_next = grant ? FULL : (out_ready ? EMPTY : occ);
    end

    // Occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) occ <= EMPTY;
        else        occ <= occ_next;
    end

    // Capture the granted word and advance the round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= sel_t'(RESET_PTR[1:0]);
            last_sel <= '0;
            out_data <= '0;
            out_src  <= '0;
        end else if (grant) begin
            ptr      <= winner + 2'd1;
            last_sel <= winner;
            out_data <= mux_data;
            out_src  <= winner;
        end
    end
endmodule
